// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;
  localparam int   CNT_W    = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signal bundle of the memory port arbiter.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          gnt0;
  logic          done0;
  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          gnt1;
  logic          done1;
  logic [DW-1:0] rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
    output gnt0, done0, gnt1, done1, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
    input  gnt0, done0, gnt1, done1, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin winner selection with a registered priority pointer.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req0_i,
  input  logic req1_i,
  input  logic advance_i,
  output logic valid_o,
  output logic winner_o
);

  logic ptr_q;
  logic ptr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= PORT_CPU;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_comb begin
    if (advance_i) begin
      ptr_d = ~ptr_q;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // a lone requester always wins; the pointer only breaks ties
  always_comb begin
    valid_o = req0_i | req1_i;
    if (req0_i && req1_i) begin
      winner_o = ptr_q;
    end else if (req1_i) begin
      winner_o = PORT_DBG;
    end else begin
      winner_o = PORT_CPU;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises CPU and debug/DMA accesses onto one memory with a fixed read latency,
// returning a one-cycle done pulse alongside registered read data.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave arb_if
);

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_mem_lat
    $error("mem_port_arbiter: MEM_LAT must be within 1..15");
  end

  arb_state_e       state_q, state_d;
  logic             owner_q, owner_d;
  logic             we_q, we_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic             done0_q, done0_d, done1_q, done1_d;
  logic             mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic             busy_q, busy_d;
  logic             sel_valid;
  logic             sel_port;

  rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .rst       (rst),
    .req0_i    (arb_if.req0),
    .req1_i    (arb_if.req1),
    .advance_i (state_q == DONE),
    .valid_o   (sel_valid),
    .winner_o  (sel_port)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= PORT_CPU;
      we_q     <= 1'b0;
      addr_q   <= {AW{1'b0}};
      wdata_q  <= {DW{1'b0}};
      rdata_q  <= {DW{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      mem_en_q <= mem_en_d;
      mem_we_q <= mem_we_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          owner_d = sel_port;
          we_d    = (sel_port == PORT_DBG) ? arb_if.we1    : arb_if.we0;
          addr_d  = (sel_port == PORT_DBG) ? arb_if.addr1  : arb_if.addr0;
          wdata_d = (sel_port == PORT_DBG) ? arb_if.wdata1 : arb_if.wdata0;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        cnt_d   = CNT_W'(MEM_LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        // counter reaching zero marks the cycle mem_rdata is valid
        if (cnt_q == {CNT_W{1'b0}}) begin
          rdata_d = arb_if.mem_rdata;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // outputs decoded from the next state so they leave the register in step with it
  always_comb begin
    busy_d   = (state_d != IDLE);
    mem_en_d = (state_d == ISSUE);
    mem_we_d = (state_d == ISSUE) && we_d;
    gnt0_d   = busy_d && (owner_d == PORT_CPU);
    gnt1_d   = busy_d && (owner_d == PORT_DBG);
    done0_d  = (state_d == DONE) && (owner_d == PORT_CPU);
    done1_d  = (state_d == DONE) && (owner_d == PORT_DBG);
  end

  assign arb_if.gnt0      = gnt0_q;
  assign arb_if.gnt1      = gnt1_q;
  assign arb_if.done0     = done0_q;
  assign arb_if.done1     = done1_q;
  assign arb_if.rdata     = rdata_q;
  assign arb_if.mem_en    = mem_en_q;
  assign arb_if.mem_we    = mem_we_q;
  assign arb_if.mem_addr  = addr_q;
  assign arb_if.mem_wdata = wdata_q;
  assign arb_if.busy      = busy_q;

endmodule
